decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/riscv_pkg.sv | 52 +++++
 rtl/imm_gen.sv | 30 +++
 rtl/decode_stage.sv | 108 ++++++++++
 tb/tb_decode_stage.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: ALU operation encoding, opcode and funct7 constants,
// and the decoded-instruction record carried by the decode stage.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_XOR  = 4'b0001,
    ALU_OR   = 4'b0010,
    ALU_AND  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_SUB  = 4'b1001
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_e     alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_we;
    logic        illegal;
  } decode_t;

  // alt selects SUB/SRA; callers only raise it where the alternate form is legal.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extraction for the supported RV32I formats.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  always_comb begin
    imm = '0;
    case (opcode)
      OPC_OP_IMM: begin
        // Shifts carry only the shift amount; the funct7 bits are not part of the value.
        if (funct3 == 3'b001 || funct3 == 3'b101)
          imm = {27'd0, instr[24:20]};
        else
          imm = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_LUI: imm = {instr[31:12], 12'h000};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage (OP, OP-IMM, LUI): combinational decode feeding a single
// registered output bank with valid/ready handshake and flush.
module decode_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        in_ready,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [3:0]  alu_op,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic        use_imm,
  output logic        reg_we,
  output logic        illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_raw;
  logic        is_shift;
  decode_t     dec;
  decode_t     q;
  logic        valid_q;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  imm_gen u_imm_gen (
    .instr (instr),
    .imm   (imm_raw)
  );

  always_comb begin
    dec         = '0;
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.rd      = instr[11:7];
    dec.illegal = 1'b1;
    is_shift    = (funct3 == 3'b001) || (funct3 == 3'b101);
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE ||
            (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          dec.illegal = 1'b0;
          dec.reg_we  = 1'b1;
          dec.alu_op  = alu_from_funct3(funct3, funct7 == F7_ALT);
        end
      end
      OPC_OP_IMM: begin
        if (!is_shift || funct7 == F7_BASE || (funct7 == F7_ALT && funct3 == 3'b101)) begin
          dec.illegal = 1'b0;
          dec.reg_we  = 1'b1;
          dec.use_imm = 1'b1;
          dec.rs2     = '0;
          dec.imm     = imm_raw;
          dec.alu_op  = alu_from_funct3(funct3, is_shift && funct7 == F7_ALT);
        end
      end
      OPC_LUI: begin
        dec.illegal = 1'b0;
        dec.reg_we  = 1'b1;
        dec.use_imm = 1'b1;
        dec.rs1     = '0;
        dec.rs2     = '0;
        dec.imm     = imm_raw;
        dec.alu_op  = ALU_ADD;
      end
      default: ;
    endcase
  end

  assign in_ready = !valid_q || out_ready;

  // Flush only drops valid; fields keep their last loaded value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (instr_valid && in_ready) begin
      valid_q <= 1'b1;
      q       <= dec;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign alu_op    = q.alu_op;
  assign rs1       = q.rs1;
  assign rs2       = q.rs2;
  assign rd        = q.rd;
  assign imm       = q.imm;
  assign use_imm   = q.use_imm;
  assign reg_we    = q.reg_we;
  assign illegal   = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a behavioural model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [3:0]  alu_op;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        use_imm, reg_we, illegal;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic        compare_on = 1'b0;

  typedef struct packed {
    logic [3:0]  alu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_we;
    logic        illegal;
  } exp_t;

  exp_t m_out = '0;
  logic m_valid = 1'b0;

  decode_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .alu_op      (alu_op),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .imm         (imm),
    .use_imm     (use_imm),
    .reg_we      (reg_we),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode from the instruction-set rules, table-driven by funct3.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    logic [3:0] base_op [8];
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       shift;
    base_op = '{4'd0, 4'd4, 4'd7, 4'd8, 4'd1, 4'd5, 4'd2, 4'd3};
    opc = w[6:0];
    f3  = w[14:12];
    f7  = w[31:25];
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    e = '0;
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd  = w[11:7];
    e.illegal = 1'b1;
    if (opc == 7'h33) begin
      if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
        e.illegal = 1'b0;
        e.reg_we  = 1'b1;
        e.alu     = base_op[f3];
        if (f7 == 7'h20) e.alu = (f3 == 3'd0) ? 4'd9 : 4'd6;
      end
    end else if (opc == 7'h13) begin
      if (!shift || f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5)) begin
        e.illegal = 1'b0;
        e.reg_we  = 1'b1;
        e.use_imm = 1'b1;
        e.rs2     = 5'd0;
        e.alu     = base_op[f3];
        if (f3 == 3'd5 && f7 == 7'h20) e.alu = 4'd6;
        e.imm = shift ? 32'(w[24:20]) : 32'($signed(w[31:20]));
      end
    end else if (opc == 7'h37) begin
      e.illegal = 1'b0;
      e.reg_we  = 1'b1;
      e.use_imm = 1'b1;
      e.rs1     = 5'd0;
      e.rs2     = 5'd0;
      e.alu     = 4'd0;
      e.imm     = {w[31:12], 12'h000};
    end
    return e;
  endfunction

  // Pipeline register model: what the outputs must show after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_out   = '0;
    end else begin
      logic accept, drain;
      accept = instr_valid && (!m_valid || out_ready);
      drain  = m_valid && out_ready;
      if (flush) begin
        m_valid = 1'b0;
      end else if (accept) begin
        m_out   = model(instr);
        m_valid = 1'b1;
      end else if (drain) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (compare_on) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      chk("alu_op", 32'(alu_op), 32'(m_out.alu));
      chk("rs1", 32'(rs1), 32'(m_out.rs1));
      chk("rs2", 32'(rs2), 32'(m_out.rs2));
      chk("rd", 32'(rd), 32'(m_out.rd));
      chk("imm", imm, m_out.imm);
      chk("use_imm", 32'(use_imm), 32'(m_out.use_imm));
      chk("reg_we", 32'(reg_we), 32'(m_out.reg_we));
      chk("illegal", 32'(illegal), 32'(m_out.illegal));
    end
  end

  task automatic offer(input logic [31:0] w);
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  f7;
    w = $urandom;
    case ($urandom_range(0, 2))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0:       w = {f7, w[24:7], 7'h33};
      1:       w = {f7, w[24:7], 7'h13};
      2:       w = {w[31:7], 7'h37};
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    #1 rst_n = 1'b0;
    compare_on = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_imm", imm, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;

    offer(32'h002081B3);
    chk("add_alu", 32'(alu_op), 32'h0);
    chk("add_rs1", 32'(rs1), 32'd1);
    chk("add_rs2", 32'(rs2), 32'd2);
    chk("add_rd", 32'(rd), 32'd3);
    chk("add_use_imm", 32'(use_imm), 32'd0);
    chk("add_reg_we", 32'(reg_we), 32'd1);
    offer(32'h402081B3);
    chk("sub_alu", 32'(alu_op), 32'h9);
    offer(32'h40335293);
    chk("srai_alu", 32'(alu_op), 32'h6);
    chk("srai_imm", imm, 32'd3);
    chk("srai_use_imm", 32'(use_imm), 32'd1);
    chk("srai_rd", 32'(rd), 32'd5);
    offer(32'hFFF00093);
    chk("addi_imm", imm, 32'hFFFFFFFF);
    offer(32'h123453B7);
    chk("lui_imm", imm, 32'h12345000);
    chk("lui_rs1", 32'(rs1), 32'd0);
    chk("lui_alu", 32'(alu_op), 32'h0);
    offer(32'h00000000);
    chk("zero_illegal", 32'(illegal), 32'd1);
    chk("zero_reg_we", 32'(reg_we), 32'd0);
    offer(32'h7E2081B3);
    chk("f7bad_illegal", 32'(illegal), 32'd1);
    chk("f7bad_reg_we", 32'(reg_we), 32'd0);
    chk("f7bad_alu", 32'(alu_op), 32'h0);

    // Stall with a word waiting, then release for back-to-back loads.
    offer(32'h002081B3);
    instr = 32'h402081B3;
    instr_valid = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_alu_hold", 32'(alu_op), 32'h0);
      chk("stall_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 instr = 32'h40335293;
    @(negedge clk);
    #1;
    chk("b2b_first_alu", 32'(alu_op), 32'h9);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("b2b_second_alu", 32'(alu_op), 32'h6);
    chk("b2b_second_valid", 32'(out_valid), 32'd1);

    // Flush beats a simultaneous offer.
    instr = 32'h123453B7;
    instr_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    instr_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_dropped_imm", imm, 32'd3);

    // Reset pulsed while stalled.
    offer(32'h002081B3);
    out_ready = 1'b0;
    instr = 32'h402081B3;
    instr_valid = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_rd", 32'(rd), 32'd0);
    chk("rst_mid_reg_we", 32'(reg_we), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_alu", 32'(alu_op), 32'h9);
    chk("post_rst_valid", 32'(out_valid), 32'd1);

    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      instr       = rand_instr();
      instr_valid = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compare_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
